// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: pipeline stage register with valid/ready handshake,
// freeze, flush, bubble insertion, optional 1-entry skid buffer and a
// saturating stall counter.
//
// Ports:
//   i_clk, i_rst      clock, async active-high reset
//   i_freeze          hazard stall, stage must not advance
//   i_flush           kill all held entries, drop the offered entry
//   i_in_valid        upstream entry valid
//   o_in_ready        stage can accept an entry this cycle
//   i_in_pc/i_in_data upstream pc / payload
//   o_out_valid       main entry valid
//   i_out_ready       downstream accepts main entry
//   o_pc/o_data       main entry pc / payload (0 / NOP_WORD for a bubble)
//   o_stall_cnt       saturating count of stalled-valid cycles
module pipe_stage_buf #(
    parameter int                PC_W     = 32,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = '0,
    parameter bit                SKID     = 1'b1,
    parameter int                CNT_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_freeze,
    input  logic              i_flush,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [PC_W-1:0]   i_in_pc,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [PC_W-1:0]   o_pc,
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t             r_state;
    logic [PC_W-1:0]    r_pc;
    logic [DATA_W-1:0]  r_data;
    logic [PC_W-1:0]    r_skid_pc;
    logic [DATA_W-1:0]  r_skid_data;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic w_adv;
    logic w_in_fire;
    logic w_out_valid;
    logic w_in_ready;

    assign w_adv       = i_out_ready & ~i_freeze;
    assign w_out_valid = (r_state != S_EMPTY);
    assign w_in_fire   = i_in_valid & w_in_ready;

    // With a skid entry, ready depends on state flops only, which cuts
    // the combinational path from downstream ready/freeze to upstream.
    generate
        if (SKID) begin : g_skid
            assign w_in_ready = (r_state != S_TWO);
        end else begin : g_noskid
            assign w_in_ready = ~w_out_valid | w_adv;
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_EMPTY;
            r_pc        <= '0;
            r_data      <= NOP_WORD;
            r_skid_pc   <= '0;
            r_skid_data <= NOP_WORD;
            r_stall_cnt <= '0;
        end else begin
            if (i_flush) begin
                r_state     <= S_EMPTY;
                r_pc        <= '0;
                r_data      <= NOP_WORD;
                r_skid_pc   <= '0;
                r_skid_data <= NOP_WORD;
            end else begin
                unique case (r_state)
                    S_EMPTY: begin
                        if (w_in_fire) begin
                            r_state <= S_ONE;
                            r_pc    <= i_in_pc;
                            r_data  <= i_in_data;
                        end
                    end
                    S_ONE: begin
                        if (w_in_fire && w_adv) begin
                            r_pc   <= i_in_pc;
                            r_data <= i_in_data;
                        end else if (w_in_fire && SKID) begin
                            // main is stuck: park the new entry behind it
                            r_state     <= S_TWO;
                            r_skid_pc   <= i_in_pc;
                            r_skid_data <= i_in_data;
                        end else if (w_adv) begin
                            r_state <= S_EMPTY;
                            r_pc    <= '0;
                            r_data  <= NOP_WORD;
                        end
                    end
                    S_TWO: begin
                        if (w_adv) begin
                            r_state     <= S_ONE;
                            r_pc        <= r_skid_pc;
                            r_data      <= r_skid_data;
                            r_skid_pc   <= '0;
                            r_skid_data <= NOP_WORD;
                        end
                    end
                    default: begin
                        r_state <= S_EMPTY;
                        r_pc    <= '0;
                        r_data  <= NOP_WORD;
                    end
                endcase
            end

            if (w_out_valid && !w_adv && !i_flush &&
                (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = w_out_valid;
    assign o_pc        = r_pc;
    assign o_data      = r_data;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed table-driven bench for pipe_stage_buf
// (SKID=1, CNT_W=4, non-zero NOP word).
module tb_pipe_stage_buf;

    localparam int          PC_W   = 32;
    localparam int          DATA_W = 32;
    localparam int          CNT_W  = 4;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic              clk;
    logic              rst;
    logic              freeze;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  stall_cnt;

    int checks;
    int failures;

    pipe_stage_buf #(
        .PC_W    (PC_W),
        .DATA_W  (DATA_W),
        .NOP_WORD(NOP),
        .SKID    (1'b1),
        .CNT_W   (CNT_W)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_freeze   (freeze),
        .i_flush    (flush),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .i_in_pc    (in_pc),
        .i_in_data  (in_data),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_pc       (pc),
        .o_data     (data),
        .o_stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] ipc;
        logic        ordy;
        logic        frz;
        logic        fl;
        logic        ev;
        logic [31:0] epc;
        logic        erdy;
        logic [3:0]  ecnt;
    } vec_t;

    vec_t vt[22];

    function automatic vec_t mk(logic iv, logic [31:0] ipc, logic ordy,
                                logic frz, logic fl, logic ev,
                                logic [31:0] epc, logic erdy,
                                logic [3:0] ecnt);
        vec_t v;
        v.iv = iv; v.ipc = ipc; v.ordy = ordy; v.frz = frz; v.fl = fl;
        v.ev = ev; v.epc = epc; v.erdy = erdy; v.ecnt = ecnt;
        return v;
    endfunction

    function automatic logic [31:0] pay(logic [31:0] p);
        return {16'hC0DE, p[15:0]};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic iv, logic [31:0] ipc, logic ordy,
                         logic frz, logic fl);
        in_valid  = iv;
        in_pc     = ipc;
        in_data   = pay(ipc);
        out_ready = ordy;
        freeze    = frz;
        flush     = fl;
    endtask

    task automatic chk_state(string tag, logic ev, logic [31:0] epc,
                             logic erdy, logic [3:0] ecnt);
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, ev});
        chk({tag, ".pc"}, pc, ev ? epc : 32'd0);
        chk({tag, ".data"}, data, ev ? pay(epc) : NOP);
        chk({tag, ".ready"}, {31'd0, in_ready}, {31'd0, erdy});
        chk({tag, ".cnt"}, {28'd0, stall_cnt}, {28'd0, ecnt});
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // iv ipc ordy frz fl | valid pc ready cnt
        vt[0]  = mk(1, 32'h00, 1, 0, 0, 1, 32'h00, 1, 4'd0);
        vt[1]  = mk(1, 32'h04, 1, 0, 0, 1, 32'h04, 1, 4'd0);
        vt[2]  = mk(1, 32'h08, 1, 0, 0, 1, 32'h08, 1, 4'd0);
        vt[3]  = mk(1, 32'h0C, 1, 0, 0, 1, 32'h0C, 1, 4'd0);
        vt[4]  = mk(1, 32'h10, 1, 0, 0, 1, 32'h10, 1, 4'd0);
        vt[5]  = mk(1, 32'h14, 0, 0, 0, 1, 32'h10, 0, 4'd1);
        vt[6]  = mk(1, 32'h18, 0, 0, 0, 1, 32'h10, 0, 4'd2);
        vt[7]  = mk(1, 32'h18, 1, 0, 0, 1, 32'h14, 1, 4'd2);
        vt[8]  = mk(1, 32'h18, 1, 0, 0, 1, 32'h18, 1, 4'd2);
        vt[9]  = mk(0, 32'h00, 1, 0, 0, 0, 32'h00, 1, 4'd2);
        vt[10] = mk(1, 32'h20, 1, 0, 0, 1, 32'h20, 1, 4'd2);
        vt[11] = mk(0, 32'h00, 1, 1, 0, 1, 32'h20, 1, 4'd3);
        vt[12] = mk(1, 32'h30, 1, 1, 0, 1, 32'h20, 0, 4'd4);
        vt[13] = mk(0, 32'h00, 1, 1, 0, 1, 32'h20, 0, 4'd5);
        vt[14] = mk(1, 32'h24, 1, 0, 0, 1, 32'h30, 1, 4'd5);
        vt[15] = mk(1, 32'h28, 0, 0, 0, 1, 32'h30, 0, 4'd6);
        vt[16] = mk(1, 32'h40, 0, 0, 1, 0, 32'h00, 1, 4'd6);
        vt[17] = mk(0, 32'h00, 1, 0, 0, 0, 32'h00, 1, 4'd6);
        vt[18] = mk(1, 32'h44, 1, 0, 0, 1, 32'h44, 1, 4'd6);
        vt[19] = mk(1, 32'h48, 1, 1, 1, 0, 32'h00, 1, 4'd6);
        vt[20] = mk(0, 32'h00, 1, 0, 0, 0, 32'h00, 1, 4'd6);
        vt[21] = mk(1, 32'h50, 0, 0, 0, 1, 32'h50, 1, 4'd6);

        rst = 1'b1;
        drive(0, 32'h0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2;
        chk_state("reset", 0, 32'h0, 1, 4'd0);
        rst = 1'b0;
        @(negedge clk);

        // vt[12] offers 0x30 while stuck in ONE under freeze: it goes to
        // skid, then drains first at vt[14] ahead of the 0x24 offer.
        for (int i = 0; i < 22; i++) begin
            drive(vt[i].iv, vt[i].ipc, vt[i].ordy, vt[i].frz, vt[i].fl);
            @(posedge clk);
            #1;
            chk_state($sformatf("vec%0d", i), vt[i].ev, vt[i].epc,
                      vt[i].erdy, vt[i].ecnt);
        end

        // saturation: main 0x50 held, 20 stalled cycles from cnt=6
        drive(0, 32'h0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 8) chk("sat.at15", {28'd0, stall_cnt}, 32'hF);
        end
        chk("sat.hold", {28'd0, stall_cnt}, 32'hF);
        chk("sat.pc", pc, 32'h50);

        // reach TWO, then async reset mid-cycle
        drive(1, 32'h54, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("two.ready", {31'd0, in_ready}, 32'd0);
        drive(0, 32'h0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk_state("async_rst", 0, 32'h0, 1, 4'd0);
        #2;
        rst = 1'b0;

        // after reset, skid content must be gone
        drive(0, 32'h0, 1, 0, 0);
        @(posedge clk);
        #1;
        chk_state("post_rst", 0, 32'h0, 1, 4'd0);
        drive(1, 32'h60, 1, 0, 0);
        @(posedge clk);
        #1;
        chk_state("post_rst_in", 1, 32'h60, 1, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
